// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the execute unit, its interface and the
// iterative multiply/divide core.
//   - Opcode encodings (5-bit; bit 4 selects the M-extension group, whose low
//     three bits form the M function code).
//   - FSM state encoding.
//   - Result constants for divide-by-zero and signed-divide overflow.
//   - Helpers that decode which operands of an M function are signed.
package alu_pkg;

    localparam int OP_W = 5;

    localparam logic [4:0] OP_ADD    = 5'b00001;
    localparam logic [4:0] OP_SUB    = 5'b00010;
    localparam logic [4:0] OP_XOR    = 5'b00011;
    localparam logic [4:0] OP_OR     = 5'b00100;
    localparam logic [4:0] OP_AND    = 5'b00101;
    localparam logic [4:0] OP_SLL    = 5'b00110;
    localparam logic [4:0] OP_SRL    = 5'b00111;
    localparam logic [4:0] OP_SRA    = 5'b01000;
    localparam logic [4:0] OP_SLT    = 5'b01001;
    localparam logic [4:0] OP_SLTU   = 5'b01010;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Widest supported XLEN; the result constants are sliced down to XLEN.
    localparam int MAX_XLEN = 64;
    localparam logic [MAX_XLEN-1:0] DIV0_QUOT = {MAX_XLEN{1'b1}};
    localparam logic [MAX_XLEN-1:0] OVF_REM   = {MAX_XLEN{1'b0}};

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM.
    function automatic logic md_signed_a(input logic [2:0] funct);
        logic sgn;
        case (funct)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b110: sgn = 1'b1;
            default:                                sgn = 1'b0;
        endcase
        return sgn;
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV, REM.
    function automatic logic md_signed_b(input logic [2:0] funct);
        logic sgn;
        case (funct)
            3'b000, 3'b001, 3'b100, 3'b110: sgn = 1'b1;
            default:                        sgn = 1'b0;
        endcase
        return sgn;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: operand/result handshake bundle of the execute unit.
//   in_valid/in_ready/in_opcode/in_a/in_b : operation offered by decode
//   out_valid/out_ready/out_result/flags   : result presented to writeback
// master = producer of operations / consumer of results; slave = the unit.
interface alu_exec_unit_if #(
    parameter int XLEN = 32,
    parameter int OP_W = alu_pkg::OP_W
);
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_opcode;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic            out_carry;
    logic            out_ovf;
    logic            out_err;

    modport master (
        output in_valid, in_opcode, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_carry, out_ovf, out_err
    );

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_carry, out_ovf, out_err
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative RV32M-style core, one radix-2 step per cycle.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : abandon the operation in progress
//   start     : load operands and begin XLEN steps (funct = M function code)
//   a, b      : rs1, rs2
//   done      : high in the cycle of the final step; result is valid then
//   result    : sign-corrected result of the final step
// Multiply is shift-add, divide is restoring; both share one 2*XLEN
// accumulator. Signed operands are reduced to magnitudes at start and the
// sign is applied on the final step. Divide-by-zero and MIN/-1 are handled
// by the caller and never started here.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      funct,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [CW-1:0]     count_r;
    logic [2*XLEN-1:0] acc_r;
    logic [XLEN-1:0]   opnd_r;
    logic [2:0]        funct_r;
    logic              neg_r;
    logic              neg_rem_r;

    logic              sa_s;
    logic              sb_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     trial_s;
    logic [2*XLEN-1:0] acc_next_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;

    // Operand magnitudes for the start cycle.
    always_comb begin
        sa_s    = md_signed_a(funct) & a[XLEN-1];
        sb_s    = md_signed_b(funct) & b[XLEN-1];
        mag_a_s = sa_s ? (-a) : a;
        mag_b_s = sb_s ? (-b) : b;
    end

    // One radix-2 step: acc = {hi, lo}. Multiply adds the multiplicand into
    // hi when lo[0] is set, then shifts right. Divide shifts {rem, quo} left
    // and keeps the trial subtraction when it does not go negative.
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                    (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        trial_s   = acc_r[2*XLEN-1:XLEN-1] - {1'b0, opnd_r};
        if (funct_r[2]) begin
            if (!trial_s[XLEN]) begin
                acc_next_s = {trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end else begin
                acc_next_s = {acc_r[2*XLEN-2:XLEN-1], acc_r[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection from the post-step accumulator.
    always_comb begin
        prod_s = neg_r ? (-acc_next_s) : acc_next_s;
        quo_s  = neg_r ? (-acc_next_s[XLEN-1:0]) : acc_next_s[XLEN-1:0];
        rem_s  = neg_rem_r ? (-acc_next_s[2*XLEN-1:XLEN]) : acc_next_s[2*XLEN-1:XLEN];
        case (funct_r)
            3'b000:                 result = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result = quo_s;
            3'b110, 3'b111:         result = rem_s;
            default:                result = {XLEN{1'b0}};
        endcase
        done = (count_r == CW'(1));
    end

    // Step counter, accumulator and sign state.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_r   <= {CW{1'b0}};
            acc_r     <= {(2*XLEN){1'b0}};
            opnd_r    <= {XLEN{1'b0}};
            funct_r   <= 3'b000;
            neg_r     <= 1'b0;
            neg_rem_r <= 1'b0;
        end else if (start) begin
            count_r   <= CW'(XLEN);
            funct_r   <= funct;
            neg_r     <= sa_s ^ sb_s;
            neg_rem_r <= sa_s;
            if (funct[2]) begin
                acc_r  <= {{XLEN{1'b0}}, mag_a_s};
                opnd_r <= mag_b_s;
            end else begin
                acc_r  <= {{XLEN{1'b0}}, mag_b_s};
                opnd_r <= mag_a_s;
            end
        end else if (count_r != {CW{1'b0}}) begin
            count_r <= count_r - CW'(1);
            acc_r   <= acc_next_s;
        end else begin
            count_r <= count_r;
            acc_r   <= acc_r;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered execute stage between operand read and writeback.
//   clk, rst : clock, synchronous active-high reset (dominates flush)
//   flush    : kill the in-flight or offered operation; nothing is emitted
//   bus      : alu_exec_unit_if.slave (operation in, result + flags out)
// ALU operations complete with latency 1. M-group operations run XLEN steps
// in alu_muldiv_iter (latency XLEN+1), except divide-by-zero and MIN/-1,
// which have fixed results and complete with latency 1. One operation in
// flight at most; in_ready is low while the iterative core is busy.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int OP_W      = alu_pkg::OP_W,
    parameter bit EN_MULDIV = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    alu_exec_unit_if.slave bus
);
    localparam int              SHW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = DIV0_QUOT[XLEN-1:0];

    logic [0:0]      state_r;
    logic            out_valid_r;
    logic [XLEN-1:0] out_result_r;
    logic            out_zero_r;
    logic            out_carry_r;
    logic            out_ovf_r;
    logic            out_err_r;

    logic [OP_W-1:0] op_s;
    logic [XLEN-1:0] a_s;
    logic [XLEN-1:0] b_s;
    logic [2:0]      funct_s;
    logic            in_ready_s;
    logic            accept_s;
    logic            m_grp_s;
    logic            div_s;
    logic            div_zero_s;
    logic            div_ovf_s;
    logic            go_busy_s;
    logic            load_s;
    logic [XLEN:0]   add_s;
    logic [XLEN:0]   sub_s;
    logic [XLEN-1:0] res_s;
    logic            carry_s;
    logic            ovf_s;
    logic            err_s;
    logic [XLEN-1:0] ld_res_s;
    logic            ld_carry_s;
    logic            ld_ovf_s;
    logic            ld_err_s;
    logic            md_done_raw_s;
    logic            md_done_s;
    logic [XLEN-1:0] md_result_s;

    assign op_s    = bus.in_opcode;
    assign a_s     = bus.in_a;
    assign b_s     = bus.in_b;
    assign funct_s = op_s[2:0];

    // Handshake and routing decisions for the offered operation.
    always_comb begin
        in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || bus.out_ready);
        accept_s   = bus.in_valid && in_ready_s && !flush;
        m_grp_s    = EN_MULDIV && op_s[OP_W-1];
        div_s      = m_grp_s && funct_s[2];
        div_zero_s = div_s && (b_s == {XLEN{1'b0}});
        div_ovf_s  = div_s && md_signed_a(funct_s) && (a_s == MIN_VAL) && (b_s == ALL_ONES);
        go_busy_s  = m_grp_s && !div_zero_s && !div_ovf_s;
        md_done_s  = md_done_raw_s && !flush;
        load_s     = (accept_s && !go_busy_s) || md_done_s;
    end

    // Single-cycle datapath: ALU ops plus the fixed-result divide corners.
    always_comb begin
        add_s   = {1'b0, a_s} + {1'b0, b_s};
        sub_s   = {1'b0, a_s} - {1'b0, b_s};
        res_s   = {XLEN{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        err_s   = 1'b0;
        if (div_zero_s) begin
            // funct[1] separates REM/REMU from DIV/DIVU
            res_s = funct_s[1] ? a_s : ALL_ONES;
            err_s = 1'b1;
        end else if (div_ovf_s) begin
            res_s = funct_s[1] ? OVF_REM[XLEN-1:0] : MIN_VAL;
            ovf_s = 1'b1;
        end else begin
            case (op_s)
                OP_W'(OP_ADD): begin
                    res_s   = add_s[XLEN-1:0];
                    carry_s = add_s[XLEN];
                    ovf_s   = (a_s[XLEN-1] == b_s[XLEN-1]) && (add_s[XLEN-1] != a_s[XLEN-1]);
                end
                OP_W'(OP_SUB): begin
                    res_s   = sub_s[XLEN-1:0];
                    carry_s = sub_s[XLEN];  // borrow: a <u b
                    ovf_s   = (a_s[XLEN-1] != b_s[XLEN-1]) && (sub_s[XLEN-1] != a_s[XLEN-1]);
                end
                OP_W'(OP_XOR):  res_s = a_s ^ b_s;
                OP_W'(OP_OR):   res_s = a_s | b_s;
                OP_W'(OP_AND):  res_s = a_s & b_s;
                OP_W'(OP_SLL):  res_s = a_s << b_s[SHW-1:0];
                OP_W'(OP_SRL):  res_s = a_s >> b_s[SHW-1:0];
                OP_W'(OP_SRA):  res_s = $signed(a_s) >>> b_s[SHW-1:0];
                OP_W'(OP_SLT):  res_s = {{(XLEN-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
                OP_W'(OP_SLTU): res_s = {{(XLEN-1){1'b0}}, (a_s < b_s)};
                default:        err_s = 1'b1;
            endcase
        end
    end

    // Select what the result register captures this cycle.
    always_comb begin
        if (md_done_s) begin
            ld_res_s   = md_result_s;
            ld_carry_s = 1'b0;
            ld_ovf_s   = 1'b0;
            ld_err_s   = 1'b0;
        end else begin
            ld_res_s   = res_s;
            ld_carry_s = carry_s;
            ld_ovf_s   = ovf_s;
            ld_err_s   = err_s;
        end
    end

    generate
        if (EN_MULDIV) begin : g_muldiv
            alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
                .clk    (clk),
                .rst    (rst),
                .flush  (flush),
                .start  (accept_s && go_busy_s),
                .funct  (funct_s),
                .a      (a_s),
                .b      (b_s),
                .done   (md_done_raw_s),
                .result (md_result_s)
            );
        end else begin : g_no_muldiv
            assign md_done_raw_s = 1'b0;
            assign md_result_s   = {XLEN{1'b0}};
        end
    endgenerate

    // IDLE/BUSY control: BUSY only while the iterative core runs.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_r <= (accept_s && go_busy_s) ? ST_BUSY : ST_IDLE;
                ST_BUSY: state_r <= md_done_s ? ST_IDLE : ST_BUSY;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Result register: load has priority over consume so a same-cycle
    // consume+accept keeps out_valid high with the new result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_result_r <= {XLEN{1'b0}};
            out_zero_r   <= 1'b0;
            out_carry_r  <= 1'b0;
            out_ovf_r    <= 1'b0;
            out_err_r    <= 1'b0;
        end else if (flush) begin
            out_valid_r  <= 1'b0;
        end else if (load_s) begin
            out_valid_r  <= 1'b1;
            out_result_r <= ld_res_s;
            out_zero_r   <= (ld_res_s == {XLEN{1'b0}});
            out_carry_r  <= ld_carry_s;
            out_ovf_r    <= ld_ovf_s;
            out_err_r    <= ld_err_s;
        end else if (bus.out_ready) begin
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_result = out_result_r;
    assign bus.out_zero   = out_zero_r;
    assign bus.out_carry  = out_carry_r;
    assign bus.out_ovf    = out_ovf_r;
    assign bus.out_err    = out_err_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with hand-computed expectations.
// The stimulus process pushes the expected response (result, flags
// {zero,carry,ovf,err}, latency, accept cycle) when an operation is accepted;
// a monitor on the falling edge pops and compares whenever a result is taken.
module tb_alu_exec_unit;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   lat_seen = 1'b0;
    exp_t sb[$];

    alu_exec_unit_if #(.XLEN(32), .OP_W(5)) bus();

    alu_exec_unit #(.XLEN(32), .OP_W(5), .EN_MULDIV(1'b1)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !flush && bus.out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: actual out_valid=1 result %h, required out_valid=0 (cycle %0d)", bus.out_result, cyc);
                end else begin
                    if (!lat_seen) begin
                        chk({sb[0].name, "_latency"}, cyc - sb[0].acc_cyc, sb[0].lat);
                        lat_seen = 1'b1;
                    end
                    if (bus.out_ready) begin
                        chk({sb[0].name, "_result"}, bus.out_result, sb[0].res);
                        chk({sb[0].name, "_flags_zcoe"},
                            {28'd0, bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_err},
                            {28'd0, sb[0].fl});
                        void'(sb.pop_front());
                        lat_seen = 1'b0;
                    end
                end
            end
        end
    end

    // Offer one operation (called just after a rising edge); returns just
    // after the accepting edge.
    task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic [3:0] fl,
                         input int lat, input bit push);
        int  waitc = 0;
        bit  done = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_a      = a;
        bus.in_b      = b;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready && !flush) begin
                done = 1'b1;
                if (push) sb.push_back('{name, res, fl, lat, cyc});
            end else begin
                waitc++;
                if (waitc > 200) begin
                    n_checks++;
                    $display("FAIL %s_accept_timeout: in_ready stayed 0, required 1 within 200 cycles", name);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL %s_drain_timeout: %0d results outstanding, required 0", name, sb.size());
            sb.delete();
            lat_seen = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({name, "_out_result"}, bus.out_result, 32'd0);
        chk({name, "_flags_zcoe"},
            {28'd0, bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_err}, 32'd0);
        chk({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_opcode = 5'd0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk); #1;

        // ALU ops back to back: each accept coincides with the previous consume
        //                                                                    flags = {zero,carry,ovf,err}
        issue("add_wrap",   OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100, 1, 1'b1);
        issue("sub_ovf",    OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0010, 1, 1'b1);
        issue("sra",        OP_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 4'b0000, 1, 1'b1);
        issue("xor",        OP_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 4'b0000, 1, 1'b1);
        issue("or",         OP_OR,   32'h12340000, 32'h00005678, 32'h12345678, 4'b0000, 1, 1'b1);
        issue("and",        OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000, 1, 1'b1);
        issue("slt",        OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1, 1'b1);
        issue("sltu",       OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000, 1, 1'b1);
        issue("sub_borrow", OP_SUB,  32'h00000001, 32'h00000002, 32'hFFFFFFFF, 4'b0100, 1, 1'b1);
        issue("sll_mask",   OP_SLL,  32'h00000001, 32'h00000023, 32'h00000008, 4'b0000, 1, 1'b1);
        issue("srl",        OP_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000, 1, 1'b1);
        issue("add_ovf",    OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0010, 1, 1'b1);
        issue("illegal",    5'b01011, 32'h00000005, 32'h00000006, 32'h00000000, 4'b1001, 1, 1'b1);
        drain("alu");

        // M group: iterative ops and the fixed-result divide corners
        issue("mulh",       OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 33, 1'b1);
        issue("mulhu",      OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0000, 33, 1'b1);
        issue("mul_neg",    OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 4'b0000, 33, 1'b1);
        issue("mulhsu",     OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 4'b0000, 33, 1'b1);
        issue("div_by0",    OP_DIV,    32'h00000007, 32'h00000000, 32'hFFFFFFFF, 4'b0001, 1, 1'b1);
        issue("rem_by0",    OP_REM,    32'h00000007, 32'h00000000, 32'h00000007, 4'b0001, 1, 1'b1);
        issue("div_ovf",    OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0010, 1, 1'b1);
        issue("rem_ovf",    OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b1010, 1, 1'b1);
        issue("div_neg",    OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 4'b0000, 33, 1'b1);
        issue("rem_neg",    OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 4'b0000, 33, 1'b1);
        issue("divu",       OP_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 4'b0000, 33, 1'b1);
        issue("remu",       OP_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 4'b0000, 33, 1'b1);
        drain("muldiv");

        // Backpressure: result and flags held, in_ready low, then released
        bus.out_ready = 1'b0;
        issue("bp_add", OP_ADD, 32'd10, 32'd20, 32'd30, 4'b0000, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_held", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_result_held", bus.out_result, 32'd30);
            chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_release", {31'd0, bus.in_ready}, 32'd1);
        drain("bp");

        // Flush on the 10th cycle of a DIVU: nothing emitted, unit idle again
        issue("divu_flushed", OP_DIVU, 32'd1000, 32'd3, 32'd0, 4'b0000, 33, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            chk("flush_no_valid", {31'd0, bus.out_valid}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        issue("add_after_flush", OP_ADD, 32'd2, 32'd3, 32'd5, 4'b0000, 1, 1'b1);
        drain("after_flush");

        // Flush in the same cycle as an offered op: the accept is dropped
        bus.in_valid  = 1'b1;
        bus.in_opcode = OP_ADD;
        bus.in_a      = 32'd1;
        bus.in_b      = 32'd1;
        flush         = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        flush         = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_wins_no_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        // Reset in the middle of a BUSY multiply
        issue("mulhu_reset", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 4'b0000, 33, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset("rst_busy");
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("rst_busy_no_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        issue("xor_after_rst", OP_XOR, 32'hAAAA5555, 32'hAAAA5555, 32'h00000000, 4'b1000, 1, 1'b1);
        drain("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
